// File: rtl/te_round_ctrl_pkg.sv
// Shared definitions for the tracking-engine round sequencer.
package te_round_ctrl_pkg;

  localparam int unsigned NUM_PHYS  = 4;   // physical correlators per round
  localparam int unsigned NUM_LOGIC = 32;  // logical channels in the enable word

  // State encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LATCH      = 3'd1;
  localparam logic [2:0] ST_FIND       = 3'd2;
  localparam logic [2:0] ST_WAIT_FIND  = 3'd3;
  localparam logic [2:0] ST_CORR_START = 3'd4;
  localparam logic [2:0] ST_CORR_WAIT  = 3'd5;
  localparam logic [2:0] ST_ROUND_END  = 3'd6;
  localparam logic [2:0] ST_DONE       = 3'd7;

  typedef enum logic [2:0] {
    StIdle      = ST_IDLE,
    StLatch     = ST_LATCH,
    StFind      = ST_FIND,
    StWaitFind  = ST_WAIT_FIND,
    StCorrStart = ST_CORR_START,
    StCorrWait  = ST_CORR_WAIT,
    StRoundEnd  = ST_ROUND_END,
    StDone      = ST_DONE
  } te_state_e;

endpackage

// File: rtl/te_round_ctrl_done_collector.sv
// Collects per-slot completion for one round and runs the round watchdog.
module te_done_collector
  import te_round_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TIMEOUT_W      = 13
) (
  input  logic                clk_i,
  input  logic                rst_b_i,
  input  logic                clear_i,      // round launch: forget previous round
  input  logic                active_i,     // waiting for correlators
  input  logic [NUM_PHYS-1:0] corr_done_i,
  input  logic [NUM_PHYS-1:0] chan_en_i,
  output logic                all_done_o,
  output logic                timeout_o
);

  localparam logic [TIMEOUT_W-1:0] WdogLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_PHYS-1:0]  done_acc_q, done_acc_d, hit;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  // Only slots that were launched this round count as completions
  assign hit = corr_done_i & chan_en_i;

  // Next-state for the accumulator and the watchdog
  always_comb begin
    done_acc_d = done_acc_q;
    wdog_d     = wdog_q;
    if (clear_i) begin
      done_acc_d = '0;
      wdog_d     = '0;
    end else if (active_i) begin
      done_acc_d = done_acc_q | hit;
      if (wdog_q != WdogLast) wdog_d = wdog_q + 1'b1;
    end
  end

  // Accumulator and watchdog registers
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      done_acc_q <= '0;
      wdog_q     <= '0;
    end else begin
      done_acc_q <= done_acc_d;
      wdog_q     <= wdog_d;
    end
  end

  // Same-cycle completions close the round without waiting a cycle
  assign all_done_o = active_i && ((done_acc_q | hit) == chan_en_i);
  assign timeout_o  = active_i && (wdog_q == WdogLast);

endmodule

// File: rtl/te_round_ctrl.sv
// Tracking-engine correlation pass sequencer: allocate, launch, collect, repeat.
module te_round_ctrl
  import te_round_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TIMEOUT_W      = 13
) (
  input  logic                 clk_i,
  input  logic                 rst_b_i,
  input  logic                 te_trigger_i,
  input  logic                 te_abort_i,
  input  logic                 clear_status_i,
  output logic                 latch_enable_channel_o,
  output logic                 start_find_o,
  output logic                 te_over_o,
  input  logic                 find_channel_done_i,
  input  logic [NUM_PHYS-1:0]  physical_channel_en_i,
  input  logic [NUM_LOGIC-1:0] channel_remain_i,
  output logic                 corr_start_o,
  output logic [NUM_PHYS-1:0]  corr_channel_en_o,
  input  logic [NUM_PHYS-1:0]  corr_done_i,
  output logic                 te_busy_o,
  output logic                 te_done_o,
  output logic [3:0]           round_count_o,
  output logic                 corr_timeout_o,
  output logic                 trigger_overrun_o
);

  te_state_e           state_q, state_d;
  logic [3:0]          round_count_q, round_count_d;
  logic [NUM_PHYS-1:0] chan_en_q, chan_en_d;
  logic                corr_timeout_q, corr_timeout_d;
  logic                trigger_overrun_q, trigger_overrun_d;
  logic                set_timeout, set_overrun;
  logic                all_done, wdog_expired;
  logic                in_corr;

  te_done_collector #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_collector (
    .clk_i       (clk_i),
    .rst_b_i     (rst_b_i),
    .clear_i     (state_q == StCorrStart),
    .active_i    (state_q == StCorrWait),
    .corr_done_i (corr_done_i),
    .chan_en_i   (chan_en_q),
    .all_done_o  (all_done),
    .timeout_o   (wdog_expired)
  );

  // Next state, round bookkeeping and sticky flags
  always_comb begin
    state_d       = state_q;
    round_count_d = round_count_q;
    chan_en_d     = chan_en_q;
    set_timeout   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (te_trigger_i) begin
          state_d       = StLatch;
          round_count_d = '0;
        end
      end
      StLatch:    state_d = StFind;
      StFind:     state_d = StWaitFind;
      StWaitFind: begin
        if (find_channel_done_i) begin
          if (physical_channel_en_i == '0) begin
            state_d = StDone;
          end else begin
            chan_en_d = physical_channel_en_i;
            state_d   = StCorrStart;
          end
        end
      end
      StCorrStart: state_d = StCorrWait;
      StCorrWait: begin
        if (all_done) begin
          state_d = StRoundEnd;
        end else if (wdog_expired) begin
          state_d     = StRoundEnd;
          set_timeout = 1'b1;
        end
      end
      StRoundEnd: begin
        if (round_count_q != 4'hF) round_count_d = round_count_q + 4'd1;
        state_d = (channel_remain_i == '0) ? StDone : StFind;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides every transition, including a pending capture or timeout
    if (te_abort_i && (state_q != StIdle)) begin
      state_d     = StIdle;
      chan_en_d   = chan_en_q;
      set_timeout = 1'b0;
    end

    set_overrun = te_trigger_i && (state_q != StIdle);

    // A set in the same cycle as a clear wins
    corr_timeout_d    = set_timeout ? 1'b1 : (clear_status_i ? 1'b0 : corr_timeout_q);
    trigger_overrun_d = set_overrun ? 1'b1 : (clear_status_i ? 1'b0 : trigger_overrun_q);
  end

  // FSM and flag registers
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      state_q           <= StIdle;
      round_count_q     <= '0;
      chan_en_q         <= '0;
      corr_timeout_q    <= 1'b0;
      trigger_overrun_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      round_count_q     <= round_count_d;
      chan_en_q         <= chan_en_d;
      corr_timeout_q    <= corr_timeout_d;
      trigger_overrun_q <= trigger_overrun_d;
    end
  end

  assign in_corr = (state_q == StCorrStart) || (state_q == StCorrWait);

  // Control strobes decoded from the registered state
  always_comb begin
    latch_enable_channel_o = (state_q == StLatch);
    start_find_o           = (state_q == StFind);
    corr_start_o           = (state_q == StCorrStart);
    // Aborting mid-round still closes the round so the allocator drops its enables
    te_over_o              = (state_q == StRoundEnd) || (te_abort_i && in_corr);
    te_done_o              = (state_q == StDone) && !te_abort_i;
    te_busy_o              = (state_q != StIdle);
  end

  assign corr_channel_en_o = chan_en_q;
  assign round_count_o     = round_count_q;
  assign corr_timeout_o    = corr_timeout_q;
  assign trigger_overrun_o = trigger_overrun_q;

endmodule

// File: tb/tb_te_round_ctrl.sv
// Directed bench for te_round_ctrl with small allocator and correlator models.
module tb_te_round_ctrl;

  logic        clk;
  logic        rst_b;
  logic        te_trigger, te_abort, clear_status;
  logic        latch_enable_channel, start_find, te_over;
  logic        find_channel_done;
  logic [3:0]  physical_channel_en;
  logic [31:0] channel_remain;
  logic        corr_start;
  logic [3:0]  corr_channel_en;
  logic [3:0]  corr_done;
  logic        te_busy, te_done;
  logic [3:0]  round_count;
  logic        corr_timeout, trigger_overrun;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state (owned by the model process)
  int cyc = 0;
  int find_cnt = 0, corr_cnt = 0;
  int over_cnt = 0, done_cnt = 0, cs_cnt = 0;
  int latch_cyc = 0, sf_cyc = 0, fd_cyc = 0, cs_cyc = 0, cd_cyc = 0;
  int over_cyc = 0, over_lat = 0, done_lat = 0, cs_lat = 0;
  logic [31:0] remain = '0;
  logic [3:0]  last_cen = '0;

  // Stimulus knobs (owned by the main process)
  logic [31:0] enable_word = '0;
  logic [3:0]  withhold = '0;
  logic [3:0]  extra = '0;
  int          trig_cyc = 0;

  te_round_ctrl #(
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_W      (5)
  ) dut (
    .clk_i                  (clk),
    .rst_b_i                (rst_b),
    .te_trigger_i           (te_trigger),
    .te_abort_i             (te_abort),
    .clear_status_i         (clear_status),
    .latch_enable_channel_o (latch_enable_channel),
    .start_find_o           (start_find),
    .te_over_o              (te_over),
    .find_channel_done_i    (find_channel_done),
    .physical_channel_en_i  (physical_channel_en),
    .channel_remain_i       (channel_remain),
    .corr_start_o           (corr_start),
    .corr_channel_en_o      (corr_channel_en),
    .corr_done_i            (corr_done),
    .te_busy_o              (te_busy),
    .te_done_o              (te_done),
    .round_count_o          (round_count),
    .corr_timeout_o         (corr_timeout),
    .trigger_overrun_o      (trigger_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Allocator takes the lowest up-to-4 remaining channels
  function automatic void alloc(input logic [31:0] r, output logic [3:0] ph,
                                output logic [31:0] rn);
    int n;
    n  = 0;
    rn = r;
    for (int i = 0; i < 32; i++) begin
      if (rn[i] && n < 4) begin
        rn[i] = 1'b0;
        n++;
      end
    end
    ph = 4'((1 << n) - 1);
  endfunction

  // Allocator and correlator models: observe outputs and drive inputs on negedge
  always @(negedge clk) begin
    logic [3:0]  ph;
    logic [31:0] rn;
    find_channel_done = 1'b0;
    corr_done         = 4'h0;
    if (!rst_b) begin
      find_cnt = 0;
      corr_cnt = 0;
    end else begin
      if (latch_enable_channel) begin
        remain         = enable_word;
        channel_remain = enable_word;
        latch_cyc      = cyc;
      end
      if (find_cnt > 0) begin
        find_cnt--;
        if (find_cnt == 0) begin
          alloc(remain, ph, rn);
          remain              = rn;
          channel_remain      = rn;
          physical_channel_en = ph;
          find_channel_done   = 1'b1;
          fd_cyc              = cyc;
        end
      end
      if (start_find) begin
        find_cnt = 2;
        sf_cyc   = cyc;
      end
      if (corr_cnt > 0) begin
        corr_cnt--;
        if (corr_cnt == 0) begin
          corr_done = (last_cen & ~withhold) | extra;
          cd_cyc    = cyc;
        end
      end
      if (corr_start) begin
        corr_cnt = 10;
        cs_cyc   = cyc;
        cs_lat   = cyc - fd_cyc;
        last_cen = corr_channel_en;
        cs_cnt++;
      end
      if (te_over) begin
        over_cnt++;
        over_lat = cyc - cd_cyc;
        over_cyc = cyc;
      end
      if (te_done) begin
        done_cnt++;
        done_lat = cyc - over_cyc;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_pass(input logic [31:0] word);
    int n;
    enable_word = word;
    te_trigger  = 1'b1;
    trig_cyc    = cyc;
    step();
    te_trigger = 1'b0;
    n = 0;
    while (te_busy && n < 3000) begin
      step();
      n++;
    end
    check_eq("pass_end_busy", 32'(te_busy), 32'd0);
  endtask

  task automatic wait_corr_start(input int base);
    int n;
    n = 0;
    while (cs_cnt == base && n < 200) begin
      step();
      n++;
    end
    check_eq("corr_start_seen", 32'(cs_cnt - base), 32'd1);
  endtask

  initial begin
    int b_over, b_done, b_cs;
    rst_b = 1'b0;
    te_trigger = 1'b0;
    te_abort = 1'b0;
    clear_status = 1'b0;
    find_channel_done = 1'b0;
    physical_channel_en = 4'h0;
    channel_remain = '0;
    corr_done = 4'h0;
    repeat (3) step();
    check_eq("reset_outputs",
             {18'd0, latch_enable_channel, start_find, te_over, corr_start, corr_channel_en,
              te_busy, te_done, round_count, corr_timeout, trigger_overrun}, 32'd0);
    rst_b = 1'b1;
    step();

    // Single round, with a stray completion on an unallocated slot
    extra = 4'h8;
    b_over = over_cnt; b_done = done_cnt; b_cs = cs_cnt;
    run_pass(32'h0000_0013);
    check_eq("t1_latch_lat", 32'(latch_cyc - trig_cyc), 32'd1);
    check_eq("t1_find_lat", 32'(sf_cyc - trig_cyc), 32'd2);
    check_eq("t1_cs_lat", 32'(cs_lat), 32'd1);
    check_eq("t1_over_lat", 32'(over_lat), 32'd1);
    check_eq("t1_done_lat", 32'(done_lat), 32'd1);
    check_eq("t1_cen", 32'(corr_channel_en), 32'h7);
    check_eq("t1_over_cnt", 32'(over_cnt - b_over), 32'd1);
    check_eq("t1_done_cnt", 32'(done_cnt - b_done), 32'd1);
    check_eq("t1_cs_cnt", 32'(cs_cnt - b_cs), 32'd1);
    check_eq("t1_rounds", 32'(round_count), 32'd1);
    extra = 4'h0;

    // Full enable word: eight rounds of four
    b_over = over_cnt; b_done = done_cnt; b_cs = cs_cnt;
    run_pass(32'hFFFF_FFFF);
    check_eq("t2_rounds", 32'(round_count), 32'd8);
    check_eq("t2_over_cnt", 32'(over_cnt - b_over), 32'd8);
    check_eq("t2_cs_cnt", 32'(cs_cnt - b_cs), 32'd8);
    check_eq("t2_done_cnt", 32'(done_cnt - b_done), 32'd1);
    check_eq("t2_done_lat", 32'(done_lat), 32'd1);
    check_eq("t2_cen", 32'(corr_channel_en), 32'hF);

    // Empty enable word: done without launching
    b_over = over_cnt; b_done = done_cnt; b_cs = cs_cnt;
    run_pass(32'h0);
    check_eq("t3_cs_cnt", 32'(cs_cnt - b_cs), 32'd0);
    check_eq("t3_over_cnt", 32'(over_cnt - b_over), 32'd0);
    check_eq("t3_done_cnt", 32'(done_cnt - b_done), 32'd1);
    check_eq("t3_rounds", 32'(round_count), 32'd0);

    // Slot 2 never completes: watchdog closes the round
    withhold = 4'h4;
    b_done = done_cnt;
    run_pass(32'h0000_0013);
    check_eq("t4_wdog_lat", 32'(over_cyc - cs_cyc), 32'd17);
    check_eq("t4_timeout", 32'(corr_timeout), 32'd1);
    check_eq("t4_done_cnt", 32'(done_cnt - b_done), 32'd1);
    check_eq("t4_rounds", 32'(round_count), 32'd1);
    check_eq("t4_no_overrun", 32'(trigger_overrun), 32'd0);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check_eq("t4_timeout_clr", 32'(corr_timeout), 32'd0);
    withhold = 4'h0;

    // Retrigger while busy, then abort in CORR_WAIT
    b_done = done_cnt; b_cs = cs_cnt;
    enable_word = 32'hFFFF_FFFF;
    te_trigger = 1'b1;
    step();
    te_trigger = 1'b0;
    wait_corr_start(b_cs);
    step();
    te_trigger = 1'b1;
    step();
    te_trigger = 1'b0;
    te_abort = 1'b1;
    #1;
    check_eq("t5_abort_over", 32'(te_over), 32'd1);
    check_eq("t5_busy_before", 32'(te_busy), 32'd1);
    step();
    te_abort = 1'b0;
    check_eq("t5_idle", 32'(te_busy), 32'd0);
    check_eq("t5_overrun", 32'(trigger_overrun), 32'd1);
    repeat (3) step();
    check_eq("t5_no_done", 32'(done_cnt - b_done), 32'd0);

    // Reset mid-pass, then a clean pass
    b_cs = cs_cnt;
    te_trigger = 1'b1;
    step();
    te_trigger = 1'b0;
    wait_corr_start(b_cs);
    rst_b = 1'b0;
    step();
    check_eq("t6_reset_outputs",
             {18'd0, latch_enable_channel, start_find, te_over, corr_start, corr_channel_en,
              te_busy, te_done, round_count, corr_timeout, trigger_overrun}, 32'd0);
    rst_b = 1'b1;
    step();
    b_over = over_cnt; b_done = done_cnt;
    run_pass(32'h0000_0013);
    check_eq("t6_rounds", 32'(round_count), 32'd1);
    check_eq("t6_done_cnt", 32'(done_cnt - b_done), 32'd1);
    check_eq("t6_over_cnt", 32'(over_cnt - b_over), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
